// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read path of the 2-master/2-slave bridge:
// bus widths, route codes and the read-address FSM state encoding.
package axi_pkg;

    localparam int ID_W    = 4;
    localparam int SID_W   = 8;
    localparam int MIDX_W  = SID_W - ID_W;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;

    localparam logic [3:0] ROUTE_NONE   = 4'b0000;
    localparam logic [3:0] ROUTE_M0_S0  = 4'b0001;
    localparam logic [3:0] ROUTE_M0_S1  = 4'b0010;
    localparam logic [3:0] ROUTE_M0_DEF = 4'b0100;
    localparam logic [3:0] ROUTE_M1_S0  = 4'b1001;
    localparam logic [3:0] ROUTE_M1_S1  = 4'b1010;
    localparam logic [3:0] ROUTE_M1_DEF = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } rd_state_e;

    typedef enum logic [1:0] {
        TGT_S0  = 2'b00,
        TGT_S1  = 2'b01,
        TGT_DEF = 2'b10
    } target_e;

    function automatic logic [3:0] route_code(input logic master, input target_e tgt);
        logic [3:0] code;
        case (tgt)
            TGT_S0:  code = master ? ROUTE_M1_S0 : ROUTE_M0_S0;
            TGT_S1:  code = master ? ROUTE_M1_S1 : ROUTE_M0_S1;
            default: code = master ? ROUTE_M1_DEF : ROUTE_M0_DEF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ar_addr_decoder.sv
// Maps a read address onto S0, S1 or the default slave by masked base compare.
module ar_addr_decoder
    import axi_pkg::*;
#(
    parameter logic [ADDR_W-1:0] S0_BASE     = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] S1_BASE     = 32'h0001_0000,
    parameter logic [ADDR_W-1:0] REGION_MASK = 32'hFFFF_0000
) (
    input  logic [ADDR_W-1:0] addr_i,
    output target_e           target_o
);

    logic [ADDR_W-1:0] region;

    assign region = addr_i & REGION_MASK;

    always_comb begin
        if (region == S0_BASE) begin
            target_o = TGT_S0;
        end else if (region == S1_BASE) begin
            target_o = TGT_S1;
        end else begin
            target_o = TGT_DEF;
        end
    end

endmodule

// File: rtl/read_addr_arbiter.sv
// Read-address arbiter: round-robin AR grant between M0/M1, decode to S0/S1/default,
// and hold the route until the last R beat of the single outstanding read completes.
module read_addr_arbiter
    import axi_pkg::*;
#(
    parameter logic [ADDR_W-1:0] S0_BASE     = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] S1_BASE     = 32'h0001_0000,
    parameter logic [ADDR_W-1:0] REGION_MASK = 32'hFFFF_0000
) (
    input  logic               ACLK,
    input  logic               ARESETn,

    input  logic [ID_W-1:0]    ARID_M0,
    input  logic [ADDR_W-1:0]  ARADDR_M0,
    input  logic [LEN_W-1:0]   ARLEN_M0,
    input  logic [SIZE_W-1:0]  ARSIZE_M0,
    input  logic [BURST_W-1:0] ARBURST_M0,
    input  logic               ARVALID_M0,
    output logic               ARREADY_M0,

    input  logic [ID_W-1:0]    ARID_M1,
    input  logic [ADDR_W-1:0]  ARADDR_M1,
    input  logic [LEN_W-1:0]   ARLEN_M1,
    input  logic [SIZE_W-1:0]  ARSIZE_M1,
    input  logic [BURST_W-1:0] ARBURST_M1,
    input  logic               ARVALID_M1,
    output logic               ARREADY_M1,

    output logic [SID_W-1:0]   ARID_S0,
    output logic [ADDR_W-1:0]  ARADDR_S0,
    output logic [LEN_W-1:0]   ARLEN_S0,
    output logic [SIZE_W-1:0]  ARSIZE_S0,
    output logic [BURST_W-1:0] ARBURST_S0,
    output logic               ARVALID_S0,
    input  logic               ARREADY_S0,

    output logic [SID_W-1:0]   ARID_S1,
    output logic [ADDR_W-1:0]  ARADDR_S1,
    output logic [LEN_W-1:0]   ARLEN_S1,
    output logic [SIZE_W-1:0]  ARSIZE_S1,
    output logic [BURST_W-1:0] ARBURST_S1,
    output logic               ARVALID_S1,
    input  logic               ARREADY_S1,

    input  logic               RVALID_S0,
    input  logic               RLAST_S0,
    input  logic               RVALID_S1,
    input  logic               RLAST_S1,
    input  logic               RREADY_M0,
    input  logic               RREADY_M1,

    output logic [3:0]         Arbiter_ARID_control,
    output logic [1:0]         Aibiter_Read_State_control
);

    rd_state_e state_q;
    logic      grant_q;     // 0: M0 owns the transaction, 1: M1
    target_e   target_q;
    logic      rr_q;        // 0: M0 wins the next tie, 1: M1
    logic [3:0] route_q;

    logic              win_m1;
    logic [ADDR_W-1:0] win_addr;
    target_e           dec_target;

    always_comb begin
        // NOTE: assign a default first so every path writes win_m1 and no latch is inferred.
        win_m1 = ARVALID_M1;
        if (ARVALID_M0 && ARVALID_M1) begin
            win_m1 = rr_q;
        end
    end

    assign win_addr = win_m1 ? ARADDR_M1 : ARADDR_M0;

    ar_addr_decoder #(
        .S0_BASE     (S0_BASE),
        .S1_BASE     (S1_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decoder (
        .addr_i   (win_addr),
        .target_o (dec_target)
    );

    // Fields of the granted master, extended with its index to form the slave-side ID.
    logic [SID_W-1:0]   g_id;
    logic [ADDR_W-1:0]  g_addr;
    logic [LEN_W-1:0]   g_len;
    logic [SIZE_W-1:0]  g_size;
    logic [BURST_W-1:0] g_burst;

    assign g_id    = {{(MIDX_W-1){1'b0}}, grant_q, (grant_q ? ARID_M1 : ARID_M0)};
    assign g_addr  = grant_q ? ARADDR_M1  : ARADDR_M0;
    assign g_len   = grant_q ? ARLEN_M1   : ARLEN_M0;
    assign g_size  = grant_q ? ARSIZE_M1  : ARSIZE_M0;
    assign g_burst = grant_q ? ARBURST_M1 : ARBURST_M0;

    logic in_addr;
    logic sel_s0;
    logic sel_s1;
    logic sel_def;
    logic ar_accept;

    assign in_addr = (state_q == ADDR);
    assign sel_s0  = in_addr && (target_q == TGT_S0);
    assign sel_s1  = in_addr && (target_q == TGT_S1);
    assign sel_def = in_addr && !sel_s0 && !sel_s1;

    assign ARVALID_S0 = sel_s0;
    assign ARID_S0    = sel_s0 ? g_id    : '0;
    assign ARADDR_S0  = sel_s0 ? g_addr  : '0;
    assign ARLEN_S0   = sel_s0 ? g_len   : '0;
    assign ARSIZE_S0  = sel_s0 ? g_size  : '0;
    assign ARBURST_S0 = sel_s0 ? g_burst : '0;

    assign ARVALID_S1 = sel_s1;
    assign ARID_S1    = sel_s1 ? g_id    : '0;
    assign ARADDR_S1  = sel_s1 ? g_addr  : '0;
    assign ARLEN_S1   = sel_s1 ? g_len   : '0;
    assign ARSIZE_S1  = sel_s1 ? g_size  : '0;
    assign ARBURST_S1 = sel_s1 ? g_burst : '0;

    // The default slave accepts unconditionally, giving a single-cycle ARREADY pulse.
    assign ar_accept  = (sel_s0 && ARREADY_S0) || (sel_s1 && ARREADY_S1) || sel_def;
    assign ARREADY_M0 = ar_accept && !grant_q;
    assign ARREADY_M1 = ar_accept &&  grant_q;

    // Default-slave responses arrive on the S0 R lines.
    logic r_last_beat;
    logic r_ready;
    logic r_done;

    assign r_last_beat = (target_q == TGT_S1) ? (RVALID_S1 && RLAST_S1) : (RVALID_S0 && RLAST_S0);
    assign r_ready     = grant_q ? RREADY_M1 : RREADY_M0;
    assign r_done      = r_last_beat && r_ready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            target_q <= TGT_S0;
            rr_q     <= 1'b0;
            route_q  <= ROUTE_NONE;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (ARVALID_M0 || ARVALID_M1) begin
                        grant_q  <= win_m1;
                        target_q <= dec_target;
                        route_q  <= route_code(win_m1, dec_target);
                        state_q  <= ADDR;
                        if (ARVALID_M0 && ARVALID_M1) begin
                            rr_q <= ~rr_q;
                        end
                    end
                end
                ADDR: begin
                    if (ar_accept) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (r_done) begin
                        state_q <= IDLE;
                        route_q <= ROUTE_NONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    route_q <= ROUTE_NONE;
                end
            endcase
        end
    end

    assign Arbiter_ARID_control       = route_q;
    assign Aibiter_Read_State_control = state_q;

endmodule

// File: tb/tb_read_addr_arbiter.sv
// Randomised bench for read_addr_arbiter: each transaction is predicted from the
// arbitration, decode and route rules and compared cycle by cycle against the DUT.
module tb_read_addr_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  ARID_M0, ARID_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [3:0]  ARLEN_M0, ARLEN_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1;
    logic        ARREADY_M0, ARREADY_M1;
    logic [7:0]  ARID_S0, ARID_S1;
    logic [31:0] ARADDR_S0, ARADDR_S1;
    logic [3:0]  ARLEN_S0, ARLEN_S1;
    logic [2:0]  ARSIZE_S0, ARSIZE_S1;
    logic [1:0]  ARBURST_S0, ARBURST_S1;
    logic        ARVALID_S0, ARVALID_S1;
    logic        ARREADY_S0, ARREADY_S1;
    logic        RVALID_S0, RLAST_S0, RVALID_S1, RLAST_S1;
    logic        RREADY_M0, RREADY_M1;
    logic [3:0]  Arbiter_ARID_control;
    logic [1:0]  Aibiter_Read_State_control;

    int n_checks = 0;
    int n_fail   = 0;
    int rr_exp   = 0;   // master that wins the next simultaneous request

    always #5 ACLK = ~ACLK;

    read_addr_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
        .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .ARID_S0(ARID_S0), .ARADDR_S0(ARADDR_S0), .ARLEN_S0(ARLEN_S0), .ARSIZE_S0(ARSIZE_S0),
        .ARBURST_S0(ARBURST_S0), .ARVALID_S0(ARVALID_S0), .ARREADY_S0(ARREADY_S0),
        .ARID_S1(ARID_S1), .ARADDR_S1(ARADDR_S1), .ARLEN_S1(ARLEN_S1), .ARSIZE_S1(ARSIZE_S1),
        .ARBURST_S1(ARBURST_S1), .ARVALID_S1(ARVALID_S1), .ARREADY_S1(ARREADY_S1),
        .RVALID_S0(RVALID_S0), .RLAST_S0(RLAST_S0), .RVALID_S1(RVALID_S1), .RLAST_S1(RLAST_S1),
        .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1),
        .Arbiter_ARID_control(Arbiter_ARID_control),
        .Aibiter_Read_State_control(Aibiter_Read_State_control)
    );

    // Observation: {route, state, ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1, S0 fields, S1 fields}
    function automatic logic [107:0] obs_all();
        return {Arbiter_ARID_control, Aibiter_Read_State_control,
                ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1,
                ARID_S0, ARADDR_S0, ARLEN_S0, ARSIZE_S0, ARBURST_S0,
                ARID_S1, ARADDR_S1, ARLEN_S1, ARSIZE_S1, ARBURST_S1};
    endfunction

    // Target: 0 = S0, 1 = S1, 2 = default slave
    function automatic int tgt_of(input logic [31:0] a);
        if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 0;
        if ((a & 32'hFFFF_0000) == 32'h0001_0000) return 1;
        return 2;
    endfunction

    // Expected observation; phase 0 = idle, 1 = address, 2 = data
    function automatic logic [107:0] exp_all(input int phase, input int m, input int t, input bit srdy,
                                             input logic [3:0] id, input logic [31:0] addr,
                                             input logic [3:0] len, input logic [2:0] sz,
                                             input logic [1:0] bst);
        logic [3:0]  route;
        logic [48:0] fld;
        bit v0, v1, acc;
        route = (phase == 0) ? 4'b0000 :
                ((m == 1) ? 4'b1000 : 4'b0000) | ((t == 0) ? 4'b0001 : (t == 1) ? 4'b0010 : 4'b0100);
        v0  = (phase == 1) && (t == 0);
        v1  = (phase == 1) && (t == 1);
        acc = (phase == 1) && ((t == 2) || srdy);
        fld = {4'(m), id, addr, len, sz, bst};
        return {route, 2'(phase), v0, v1, acc && (m == 0), acc && (m == 1),
                v0 ? fld : 49'd0, v1 ? fld : 49'd0};
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [15:0] lo;
        lo = 16'($urandom);
        case ($urandom_range(0, 2))
            0:       return {16'h0000, lo};
            1:       return {16'h0001, lo};
            default: return {16'($urandom_range(2, 16'hFFFF)), lo};
        endcase
    endfunction

    task automatic tick();
        @(negedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        ARVALID_M0 = 0; ARID_M0 = 0; ARADDR_M0 = 0; ARLEN_M0 = 0; ARSIZE_M0 = 0; ARBURST_M0 = 0;
        ARVALID_M1 = 0; ARID_M1 = 0; ARADDR_M1 = 0; ARLEN_M1 = 0; ARSIZE_M1 = 0; ARBURST_M1 = 0;
        ARREADY_S0 = 0; ARREADY_S1 = 0;
        RVALID_S0 = 0; RLAST_S0 = 0; RVALID_S1 = 0; RLAST_S1 = 0;
        RREADY_M0 = 0; RREADY_M1 = 0;
    endtask

    // Drives the routed R path and granted RREADY; the other path and master look ready-and-last.
    task automatic drive_r(input int t, input int w, input bit rv, input bit rl, input bit rr);
        if (t == 1) begin
            RVALID_S1 = rv; RLAST_S1 = rl; RVALID_S0 = 1; RLAST_S0 = 1;
        end else begin
            RVALID_S0 = rv; RLAST_S0 = rl; RVALID_S1 = 1; RLAST_S1 = 1;
        end
        if (w == 0) begin
            RREADY_M0 = rr; RREADY_M1 = 1;
        end else begin
            RREADY_M1 = rr; RREADY_M0 = 1;
        end
    endtask

    // One complete read transaction starting from IDLE, checked at every cycle.
    task automatic run_txn(input string tag, input bit req0, input bit req1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [3:0] l0, input logic [3:0] l1,
                           input int stall, input bit gaps, input bit late1);
        logic [3:0]  id [2];
        logic [2:0]  sz [2];
        logic [1:0]  bst[2];
        logic [31:0] ad [2];
        logic [3:0]  ln [2];
        logic [107:0] got, exp;
        int w, t, beats;
        for (int i = 0; i < 2; i++) begin
            id[i]  = 4'($urandom);
            sz[i]  = 3'($urandom);
            bst[i] = 2'($urandom);
        end
        ad[0] = a0; ad[1] = a1; ln[0] = l0; ln[1] = l1;
        ARVALID_M0 = req0; ARID_M0 = id[0]; ARADDR_M0 = a0; ARLEN_M0 = l0; ARSIZE_M0 = sz[0]; ARBURST_M0 = bst[0];
        ARVALID_M1 = req1; ARID_M1 = id[1]; ARADDR_M1 = a1; ARLEN_M1 = l1; ARSIZE_M1 = sz[1]; ARBURST_M1 = bst[1];
        ARREADY_S0 = 0; ARREADY_S1 = 0;
        drive_r(0, 0, 0, 0, 0);
        RVALID_S1 = 0; RLAST_S1 = 0; RREADY_M1 = 0;
        if (req0 && req1) begin
            w = rr_exp;
            rr_exp = 1 - rr_exp;
        end else begin
            w = req1 ? 1 : 0;
        end
        t = tgt_of(ad[w]);
        beats = int'(ln[w]) + 1;
        #1;
        got = obs_all();
        exp = exp_all(0, w, t, 0, id[w], ad[w], ln[w], sz[w], bst[w]);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/idle: got %h expected %h", tag, got, exp);
        end
        tick();

        if (t != 2) begin
            for (int k = 0; k < stall; k++) begin
                ARREADY_S0 = (t == 1);
                ARREADY_S1 = (t == 0);
                #1;
                got = obs_all();
                exp = exp_all(1, w, t, 0, id[w], ad[w], ln[w], sz[w], bst[w]);
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL %s/stall%0d: got %h expected %h", tag, k, got, exp);
                end
                tick();
            end
        end
        ARREADY_S0 = (t != 2);
        ARREADY_S1 = (t != 2);
        #1;
        got = obs_all();
        exp = exp_all(1, w, t, t != 2, id[w], ad[w], ln[w], sz[w], bst[w]);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/accept: got %h expected %h", tag, got, exp);
        end
        tick();

        if (w == 0) ARVALID_M0 = 0; else ARVALID_M1 = 0;
        ARREADY_S0 = 0; ARREADY_S1 = 0;
        if (late1) ARVALID_M1 = 1;
        for (int b = 0; b < beats; b++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                drive_r(t, w, 1, 1, 0);
                #1;
                got = obs_all();
                exp = exp_all(2, w, t, 0, id[w], ad[w], ln[w], sz[w], bst[w]);
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL %s/gap%0d: got %h expected %h", tag, b, got, exp);
                end
                tick();
            end
            drive_r(t, w, 1, b == beats - 1, 1);
            #1;
            got = obs_all();
            exp = exp_all(2, w, t, 0, id[w], ad[w], ln[w], sz[w], bst[w]);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s/beat%0d: got %h expected %h", tag, b, got, exp);
            end
            tick();
        end
        RVALID_S0 = 0; RLAST_S0 = 0; RVALID_S1 = 0; RLAST_S1 = 0; RREADY_M0 = 0; RREADY_M1 = 0;
        #1;
        got = obs_all();
        n_checks++;
        if (got !== 108'd0) begin
            n_fail++;
            $display("FAIL %s/done: got %h expected %h", tag, got, 108'd0);
        end
    endtask

    task automatic test_reset();
        logic [107:0] got;
        clear_inputs();
        ARESETn = 1;
        #2 ARESETn = 0;
        #1;
        got = obs_all();
        n_checks++;
        if (got !== 108'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", got, 108'd0);
        end
        tick();
        tick();
        ARESETn = 1;
        ARVALID_M0 = 0;
        tick();
        got = obs_all();
        n_checks++;
        if (got !== 108'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", got, 108'd0);
        end
        rr_exp = 0;
    endtask

    task automatic test_s0_burst();
        run_txn("s0_burst", 1, 0, 32'h0000_0010, 32'h0, 4'd3, 4'd0, 0, 0, 0);
    endtask

    task automatic test_s1_backpressure();
        run_txn("s1_stall", 0, 1, 32'h0, 32'h0001_0004, 4'd0, 4'd1, 3, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_txn($sformatf("both%0d", i), 1, 1, 32'h0000_0010 + 32'(i * 4),
                    32'h0001_0000 + 32'(i * 4), 4'(i), 4'(i + 1), i % 2, 0, 0);
        end
    endtask

    task automatic test_default();
        run_txn("default", 1, 0, 32'h2000_0000, 32'h0, 4'd1, 4'd0, 0, 0, 0);
    endtask

    task automatic test_queued();
        run_txn("queued_m0", 1, 0, 32'h0000_0030, 32'h0001_0030, 4'd2, 4'd0, 0, 0, 1);
        run_txn("queued_m1", 0, 1, 32'h0000_0030, 32'h0001_0030, 4'd0, 4'd0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        logic [107:0] got;
        if (rr_exp == 0) begin
            run_txn("rst_pre", 1, 1, 32'h0000_0100, 32'h0001_0100, 4'd0, 4'd0, 0, 0, 0);
        end
        clear_inputs();
        ARVALID_M0 = 1; ARID_M0 = 4'h5; ARADDR_M0 = 32'h0000_0020; ARLEN_M0 = 4'd3;
        ARREADY_S0 = 1;
        tick();
        tick();
        ARVALID_M0 = 0; ARREADY_S0 = 0;
        #1;
        got = obs_all();
        n_checks++;
        if (got[107:102] !== 6'b0001_10) begin
            n_fail++;
            $display("FAIL rst_mid_data: got %h expected %h", got[107:102], 6'b0001_10);
        end
        ARESETn = 0;
        #1;
        got = obs_all();
        n_checks++;
        if (got !== 108'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got %h expected %h", got, 108'd0);
        end
        tick();
        tick();
        ARESETn = 1;
        rr_exp = 0;
        tick();
        run_txn("rst_after", 1, 1, 32'h0000_0040, 32'h0001_0040, 4'd1, 4'd0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            run_txn($sformatf("rand%0d", i), (pat & 1) != 0, (pat & 2) != 0,
                    rand_addr(), rand_addr(), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                    $urandom_range(0, 3), 1, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_s0_burst();
        test_s1_backpressure();
        test_back_to_back();
        test_default();
        test_queued();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/read_addr_arbiter.md
Name: read_addr_arbiter

Overview:
Upstream stage of Read_data_channel in the 2-master/2-slave AXI bridge. It arbitrates AR requests from M0/M1 round-robin, decodes the address to S0, S1 or the default slave, and forwards the AR handshake. It holds the route until the final read beat (RLAST) completes. It drives Arbiter_ARID_control and Aibiter_Read_State_control consumed by the read data channel. One outstanding read transaction system-wide.

Parameters:
S0_BASE, 32'h0000_0000, S0 region base (64 KiB).
S1_BASE, 32'h0001_0000, S1 region base (64 KiB).
REGION_MASK, 32'hFFFF_0000, mask applied before base compare.

Ports:
ACLK input 1 clock
ARESETn input 1 asynchronous active-low reset
ARID_M0/ARID_M1 input 4 master read IDs
ARADDR_M0/ARADDR_M1 input 32 read addresses
ARLEN_M0/ARLEN_M1 input 4 burst length-1
ARSIZE_M0/ARSIZE_M1 input 3 beat size
ARBURST_M0/ARBURST_M1 input 2 burst type
ARVALID_M0/ARVALID_M1 input 1 request valid
ARREADY_M0/ARREADY_M1 output 1 request accepted
ARID_S0/ARID_S1 output 8 {4-bit master index, ARID}
ARADDR_S0/ARADDR_S1 output 32; ARLEN_S0/S1 output 4; ARSIZE_S0/S1 output 3; ARBURST_S0/S1 output 2 forwarded fields
ARVALID_S0/ARVALID_S1 output 1 slave request valid
ARREADY_S0/ARREADY_S1 input 1 slave accept
RVALID_S0/RVALID_S1, RLAST_S0/RLAST_S1 input 1 R-beat observation (default slave responds on the S0 R lines, muxed at top level)
RREADY_M0/RREADY_M1 input 1 R-beat observation
Arbiter_ARID_control output 4 route: 0001 M0-S0, 0010 M0-S1, 0100 M0-DEF, 1001 M1-S0, 1010 M1-S1, 1100 M1-DEF, 0000 none
Aibiter_Read_State_control output 2 FSM state encoding

Behaviour:
- Reset (async): state IDLE; route 0000; rr pointer = M0; all ARREADY_M*/ARVALID_S* 0; ARID/ARADDR/ARLEN/ARSIZE/ARBURST_S* 0.
- State encoding: IDLE=00, ADDR=01, DATA=10. 11 is illegal and recovers to IDLE.
- IDLE: if exactly one ARVALID_Mx is high, grant that master. If both are high, grant the rr-pointer master, and the pointer moves to the other master. Latch the master index and decoded target on the next ACLK edge, then go to ADDR. Route is 0000 and all outputs are 0 while in IDLE.
- Decode: (ARADDR & REGION_MASK)==S0_BASE selects S0; ==S1_BASE selects S1; else DEF.
- ADDR: the selected slave's AR fields are driven combinationally from the granted master; ARVALID_Sx=1. ARREADY_Mgrant = ARREADY_Sx. On ARVALID_Sx & ARREADY_Sx, go to DATA.
- ADDR with DEF target: no ARVALID_S*. ARREADY_Mgrant=1 for exactly one cycle, then DATA.
- The non-granted master always sees ARREADY=0. The non-selected slave sees ARVALID=0 with fields driven to 0.
- DATA: route is held. Leave to IDLE on RVALID & RREADY & RLAST of the routed path: S0 lines for S0/DEF, S1 lines for S1; RREADY from the granted master. Non-last beats keep DATA.
- Latency: ARVALID_M in cycle 0 (IDLE) gives ARVALID_S in cycle 1. The earliest re-grant is the cycle after the last-beat handshake.
- A master that deasserts ARVALID in ADDR is a protocol violation; it need not be handled, and the FSM keeps its state.
- Reset mid-transaction returns to IDLE immediately, with route 0000.

Decomposition:
- Shared package axi_pkg holds: the route code constants (ROUTE_M0_S0, etc.), the state enum {IDLE, ADDR, DATA}, and the AXI width constants (ID 4/8, ADDR 32, LEN 4).
- One sub-module, ar_addr_decoder: combinational address to {S0, S1, DEF}, parameterised by the bases and the mask.

Test Plan:
- M0 ARADDR=0x0000_0010, ARLEN=3: route becomes 0001 in cycle 1, ARID_S0={4'h0,ID}. ARREADY_S0 is high, so the FSM enters DATA. Three non-last beats stay in DATA; the RLAST beat returns to IDLE and route 0000.
- M1 ARADDR=0x0001_0004: route 1010 and ARID_S1={4'h1,ID}. ARREADY_S1 is held low for 3 cycles: ARVALID_S1 stays 1 and ARREADY_M1 stays 0 until the slave accepts.
- M0 and M1 ARVALID high together, twice in succession: the first grant goes to M0 (route 0001/0010) and the second to M1. Pointer alternation is verified across 4 transactions.
- M0 ARADDR=0x2000_0000: route 0100, ARVALID_S0/S1 stay 0, and ARREADY_M0 is a one-cycle pulse. The default RLAST on the S0 lines with RREADY_M0 returns to IDLE.
- M1 issues a request while M0 is in DATA: ARREADY_M1 stays 0 until M0's RLAST handshake; M1 is then granted in the next cycle.
- ARESETn is asserted in DATA: outputs are 0 asynchronously and route 0000. After release, a new request proceeds normally.
